fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 i_Clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_Reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 o_MemReq  out  1  SHALL be the instruction-memory read request.
REQ-005 o_MemAddr  out  32  SHALL be the fetch address, equal to o_PC.
REQ-006 i_MemAck  in  1  SHALL be the memory acknowledge; i_MemData is valid in the same cycle.
REQ-007 i_MemData  in  32  SHALL be the instruction word returned by memory.
REQ-008 o_Inst  out  32  SHALL be the instruction presented to the decoder.
REQ-009 o_InstValid  out  1  SHALL indicate that o_Inst and o_PC are valid.
REQ-010 i_InstReady  in  1  SHALL indicate that the decode/execute side consumes o_Inst this cycle.
REQ-011 i_PCNextSel  in  2  SHALL select the next PC: 00 PC+4, 01 PC+i_Offset, 10 (i_RS1Data+i_Offset) with bit0 cleared, 11 PC+4.
REQ-012 i_Offset  in  32  SHALL be the sign-extended branch/jump offset.
REQ-013 i_RS1Data  in  32  SHALL be the RS1 value for indirect jumps.
REQ-014 o_PC  out  32  SHALL be the address of the current instruction.
REQ-015 o_PC4  out  32  SHALL be o_PC+4, combinational, used for link writes.
REQ-016 o_Fault  out  1  SHALL flag a misaligned fetch target (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, REQ, VALID and FAULT.
REQ-018 IDLE SHALL go to REQ on the first clock after reset release.
REQ-019 In REQ, o_MemReq SHALL be 1 and o_MemAddr SHALL stay stable until a cycle where i_MemAck=1.
REQ-020 On REQ with i_MemAck=1, i_MemData SHALL be captured into o_Inst and the FSM SHALL go to VALID; an ack in the first REQ cycle is legal.
REQ-021 i_MemAck outside REQ SHALL be ignored.
REQ-022 In VALID, o_InstValid SHALL be 1, and o_Inst and o_PC SHALL hold until i_InstReady=1.
REQ-023 On VALID with i_InstReady=1, the next PC SHALL be computed from i_PCNextSel, i_Offset and i_RS1Data in that same cycle, loaded into o_PC, and the FSM SHALL go to REQ.
REQ-024 Minimum throughput SHALL be one instruction per two cycles: one REQ cycle with ack, one VALID cycle with ready.
REQ-025 All PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 SHALL wrap to 32'h0000_0000 without a flag.
REQ-026 i_PCNextSel, i_Offset and i_RS1Data SHALL be ignored unless the FSM is in VALID and i_InstReady=1.
REQ-027 FAULT SHALL be left only by reset; in FAULT, o_MemReq=0, o_InstValid=0 and o_Fault=1.

Reset
REQ-028 Reset assertion SHALL immediately force:
- FSM to IDLE
- o_PC to RESET_VECTOR
- o_Inst to 32'h0000_0013 (NOP)
- o_MemReq, o_InstValid and o_Fault to 0
REQ-029 Reset asserted during REQ SHALL abandon the outstanding request; a later i_MemAck SHALL be ignored unless the FSM is in REQ.

Configuration
REQ-030 With FETCH_STAGE_MISALIGN_TRAP_EN defined, a next PC with bit1=1 SHALL:
- leave o_PC unchanged
- move the FSM to FAULT
- issue no memory request
REQ-031 Without FETCH_STAGE_MISALIGN_TRAP_EN, next-PC bits[1:0] SHALL be forced to 00, o_Fault SHALL be tied to 0, and FAULT SHALL be unreachable.

Verification
REQ-032 Reset release, then ack in the first REQ cycle with data 32'h00A00093 -> o_MemAddr=0, then o_InstValid=1, o_Inst=32'h00A00093, o_PC=0, o_PC4=4.
REQ-033 Ack delayed 3 cycles -> o_MemReq stays 1 and o_MemAddr stays stable for 4 cycles; o_InstValid stays 0 until the cycle after the ack.
REQ-034 VALID at PC=32'h100 with i_InstReady=0 for 2 cycles, then 1 with i_PCNextSel=01 and i_Offset=32'hFFFF_FFF8 -> o_Inst holds for those 2 cycles; next o_MemAddr=32'h0F8.
REQ-035 i_PCNextSel=10, i_RS1Data=32'h2001, i_Offset=4 -> next PC=32'h2004 (bit0 cleared).
REQ-036 With the macro defined: i_PCNextSel=01, PC=0, i_Offset=6 -> o_Fault=1, no further o_MemReq until reset; without the macro -> o_MemAddr=4.
REQ-037 Reset pulse while in REQ, with the ack arriving during reset -> outputs at reset values, ack ignored, fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch controller. It issues one instruction-memory read at a
//   time, holds the returned word for the decoder until it is consumed, then
//   computes the next PC from the decoder's branch/jump selection.
//
//   State    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | just out of reset, one cycle before the first request
//   S_REQ    | memory read outstanding at r_PC, waiting for i_MemAck
//   S_VALID  | o_Inst/o_PC presented to decoder, waiting for i_InstReady
//   S_FAULT  | misaligned next PC trapped; only reset leaves this state
//
// Ports
//   i_Clock      clock, rising edge
//   i_Reset      asynchronous active-low reset
//   o_MemReq     instruction-memory read request
//   o_MemAddr    fetch address (always equal to o_PC)
//   i_MemAck     memory acknowledge, i_MemData valid in the same cycle
//   i_MemData    instruction word from memory
//   o_Inst       instruction for the decoder
//   o_InstValid  o_Inst and o_PC are valid
//   i_InstReady  decoder consumes o_Inst this cycle
//   i_PCNextSel  00/11 PC+4, 01 PC+i_Offset, 10 (i_RS1Data+i_Offset)&~1
//   i_Offset     sign-extended branch/jump offset
//   i_RS1Data    base register for indirect jumps
//   o_PC         address of the current instruction
//   o_PC4        o_PC+4 for link writes
//   o_Fault      misaligned fetch target trapped
//
// Build option
//   FETCH_STAGE_MISALIGN_TRAP_EN  when defined, a next PC with bit1 set
//   traps into S_FAULT instead of being silently word-aligned.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    output logic        o_MemReq,
    output logic [31:0] o_MemAddr,
    input  logic        i_MemAck,
    input  logic [31:0] i_MemData,
    output logic [31:0] o_Inst,
    output logic        o_InstValid,
    input  logic        i_InstReady,
    input  logic [1:0]  i_PCNextSel,
    input  logic [31:0] i_Offset,
    input  logic [31:0] i_RS1Data,
    output logic [31:0] o_PC,
    output logic [31:0] o_PC4,
    output logic        o_Fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_State;
    state_t      w_NextState;
    logic [31:0] r_PC;
    logic [31:0] r_Inst;
    logic [31:0] w_PCTarget;
    logic [31:0] w_PCNext;
    logic        w_Misaligned;
    logic        w_LoadPC;
    logic        w_LoadInst;

    // Raw jump/branch target; arithmetic wraps modulo 2^32 naturally.
    always_comb begin
        w_PCTarget = r_PC + 32'd4;
        case (i_PCNextSel)
            2'b01:   w_PCTarget = r_PC + i_Offset;
            2'b10:   w_PCTarget = (i_RS1Data + i_Offset) & ~32'h0000_0001;
            default: w_PCTarget = r_PC + 32'd4;
        endcase
    end

    // Loaded PC is always word aligned; with the trap enabled a set bit1
    // never reaches r_PC because the FSM diverts to S_FAULT instead.
    assign w_PCNext = w_PCTarget & ~32'h0000_0003;

`ifdef FETCH_STAGE_MISALIGN_TRAP_EN
    assign w_Misaligned = w_PCTarget[1];
`else
    assign w_Misaligned = 1'b0;
`endif

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    always_comb begin
        w_NextState = r_State;
        w_LoadPC    = 1'b0;
        w_LoadInst  = 1'b0;
        case (r_State)
            S_IDLE: begin
                w_NextState = S_REQ;
            end
            S_REQ: begin
                if (i_MemAck) begin
                    w_LoadInst  = 1'b1;
                    w_NextState = S_VALID;
                end
            end
            S_VALID: begin
                if (i_InstReady) begin
                    if (w_Misaligned) begin
                        w_NextState = S_FAULT;
                    end else begin
                        w_LoadPC    = 1'b1;
                        w_NextState = S_REQ;
                    end
                end
            end
            S_FAULT: begin
                w_NextState = S_FAULT;
            end
            default: begin
                w_NextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_PC   <= RESET_VECTOR;
            r_Inst <= NOP;
        end else begin
            if (w_LoadPC) begin
                r_PC <= w_PCNext;
            end
            if (w_LoadInst) begin
                r_Inst <= i_MemData;
            end
        end
    end

    assign o_MemReq    = (r_State == S_REQ);
    assign o_MemAddr   = r_PC;
    assign o_PC        = r_PC;
    assign o_PC4       = r_PC + 32'd4;
    assign o_Inst      = r_Inst;
    assign o_InstValid = (r_State == S_VALID);

`ifdef FETCH_STAGE_MISALIGN_TRAP_EN
    assign o_Fault = (r_State == S_FAULT);
`else
    assign o_Fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Inputs change and outputs are sampled
//   1 ns after each rising edge, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        i_Clock;
    logic        i_Reset;
    logic        o_MemReq;
    logic [31:0] o_MemAddr;
    logic        i_MemAck;
    logic [31:0] i_MemData;
    logic [31:0] o_Inst;
    logic        o_InstValid;
    logic        i_InstReady;
    logic [1:0]  i_PCNextSel;
    logic [31:0] i_Offset;
    logic [31:0] i_RS1Data;
    logic [31:0] o_PC;
    logic [31:0] o_PC4;
    logic        o_Fault;

    int n_checks = 0;
    int n_errors = 0;

    fetch_stage #(.RESET_VECTOR(32'h0000_0000)) u_dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .o_MemReq    (o_MemReq),
        .o_MemAddr   (o_MemAddr),
        .i_MemAck    (i_MemAck),
        .i_MemData   (i_MemData),
        .o_Inst      (o_Inst),
        .o_InstValid (o_InstValid),
        .i_InstReady (i_InstReady),
        .i_PCNextSel (i_PCNextSel),
        .i_Offset    (i_Offset),
        .i_RS1Data   (i_RS1Data),
        .o_PC        (o_PC),
        .o_PC4       (o_PC4),
        .o_Fault     (o_Fault)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic idle_inputs();
        i_MemAck    = 1'b0;
        i_InstReady = 1'b0;
        i_PCNextSel = 2'b00;
        i_Offset    = 32'h0;
        i_RS1Data   = 32'h0;
    endtask

    // From REQ: ack with data, then expect VALID at pc.
    task automatic fetch_ack(input logic [31:0] data, input logic [31:0] pc);
        i_MemAck  = 1'b1;
        i_MemData = data;
        tick();
        idle_inputs();
        chk("valid_after_ack", {31'b0, o_InstValid}, 32'd1);
        chk("inst_after_ack", o_Inst, data);
        chk("pc_after_ack", o_PC, pc);
    endtask

    // From VALID: consume with the given selection, expect REQ at addr.
    task automatic consume(input logic [1:0] sel, input logic [31:0] off,
                           input logic [31:0] rs1, input logic [31:0] addr);
        i_InstReady = 1'b1;
        i_PCNextSel = sel;
        i_Offset    = off;
        i_RS1Data   = rs1;
        tick();
        idle_inputs();
        chk("req_after_ready", {31'b0, o_MemReq}, 32'd1);
        chk("addr_after_ready", o_MemAddr, addr);
    endtask

    initial begin
        i_Reset   = 1'b0;
        i_MemData = 32'h0;
        idle_inputs();
        tick();

        // reset values
        chk("rst_memreq", {31'b0, o_MemReq}, 32'd0);
        chk("rst_valid", {31'b0, o_InstValid}, 32'd0);
        chk("rst_fault", {31'b0, o_Fault}, 32'd0);
        chk("rst_pc", o_PC, 32'h0);
        chk("rst_inst", o_Inst, 32'h0000_0013);
        chk("rst_pc4", o_PC4, 32'h4);

        // IDLE -> REQ on first edge after release, ack in first REQ cycle
        i_Reset = 1'b1;
        tick();
        chk("first_req", {31'b0, o_MemReq}, 32'd1);
        chk("first_addr", o_MemAddr, 32'h0);
        fetch_ack(32'h00A0_0093, 32'h0);
        chk("first_pc4", o_PC4, 32'h4);
        chk("valid_no_req", {31'b0, o_MemReq}, 32'd0);

        // sequential next PC, then ack delayed three cycles
        consume(2'b00, 32'h0, 32'h0, 32'h4);
        for (int i = 0; i < 3; i++) begin
            chk("wait_req", {31'b0, o_MemReq}, 32'd1);
            chk("wait_addr", o_MemAddr, 32'h4);
            chk("wait_valid", {31'b0, o_InstValid}, 32'd0);
            tick();
        end
        chk("wait_req4", {31'b0, o_MemReq}, 32'd1);
        chk("wait_addr4", o_MemAddr, 32'h4);
        fetch_ack(32'h1111_1111, 32'h4);

        // branch to 0x100, hold VALID for two cycles with noise on ignored inputs
        consume(2'b01, 32'h0000_00FC, 32'h0, 32'h100);
        fetch_ack(32'hDEAD_0001, 32'h100);
        for (int i = 0; i < 2; i++) begin
            i_MemAck    = 1'b1;
            i_MemData   = 32'h5555_5555;
            i_PCNextSel = 2'b10;
            i_Offset    = 32'h40;
            i_RS1Data   = 32'h8000;
            tick();
            chk("hold_valid", {31'b0, o_InstValid}, 32'd1);
            chk("hold_inst", o_Inst, 32'hDEAD_0001);
            chk("hold_pc", o_PC, 32'h100);
        end
        idle_inputs();
        consume(2'b01, 32'hFFFF_FFF8, 32'h0, 32'h0000_00F8);

        // indirect jump clears bit0
        fetch_ack(32'h2222_2222, 32'hF8);
        consume(2'b10, 32'h4, 32'h2001, 32'h2004);

        // wrap at top of address space
        fetch_ack(32'h3333_3333, 32'h2004);
        consume(2'b01, 32'hFFFF_DFF8, 32'h0, 32'hFFFF_FFFC);
        fetch_ack(32'h4444_4444, 32'hFFFF_FFFC);
        chk("wrap_pc4", o_PC4, 32'h0);
        consume(2'b00, 32'h0, 32'h0, 32'h0);
        chk("wrap_no_fault", {31'b0, o_Fault}, 32'd0);

        // sel 11 behaves as PC+4
        fetch_ack(32'h5555_0000, 32'h0);
        consume(2'b11, 32'h0000_1000, 32'h0000_3000, 32'h4);

        // reset pulse in REQ with ack arriving during reset
        i_Reset = 1'b0;
        #1;
        chk("rstreq_memreq", {31'b0, o_MemReq}, 32'd0);
        chk("rstreq_pc", o_PC, 32'h0);
        chk("rstreq_inst", o_Inst, 32'h0000_0013);
        i_MemAck  = 1'b1;
        i_MemData = 32'h0BAD_0BAD;
        tick();
        tick();
        chk("rstack_inst", o_Inst, 32'h0000_0013);
        chk("rstack_valid", {31'b0, o_InstValid}, 32'd0);
        i_MemAck = 1'b0;
        i_Reset  = 1'b1;
        tick();
        chk("restart_req", {31'b0, o_MemReq}, 32'd1);
        chk("restart_addr", o_MemAddr, 32'h0);
        chk("restart_valid", {31'b0, o_InstValid}, 32'd0);
        fetch_ack(32'h0010_0093, 32'h0);

        // misaligned target
        i_InstReady = 1'b1;
        i_PCNextSel = 2'b01;
        i_Offset    = 32'h6;
        tick();
        idle_inputs();
`ifdef FETCH_STAGE_MISALIGN_TRAP_EN
        chk("mis_fault", {31'b0, o_Fault}, 32'd1);
        chk("mis_pc", o_PC, 32'h0);
        for (int i = 0; i < 3; i++) begin
            i_MemAck    = 1'b1;
            i_InstReady = 1'b1;
            tick();
            chk("fault_memreq", {31'b0, o_MemReq}, 32'd0);
            chk("fault_valid", {31'b0, o_InstValid}, 32'd0);
            chk("fault_hold", {31'b0, o_Fault}, 32'd1);
        end
        idle_inputs();
`else
        chk("mis_fault", {31'b0, o_Fault}, 32'd0);
        chk("mis_req", {31'b0, o_MemReq}, 32'd1);
        chk("mis_addr", o_MemAddr, 32'h4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
